// File: rtl/div_share_ctrl_if.sv
// Bundle of requester-side and divider-side handshakes for div_share_ctrl.
// The controller uses the slave view; requesters and the divider use the master view.
interface div_share_ctrl_if #(
  parameter int DW = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [DW-1:0]   req0_a;
  logic [DW-1:0]   req0_b;
  logic            req0_sign;
  logic            req0_flush;
  logic            resp0_valid;
  logic            resp0_ready;

  logic            req1_valid;
  logic            req1_ready;
  logic [DW-1:0]   req1_a;
  logic [DW-1:0]   req1_b;
  logic            req1_sign;
  logic            req1_flush;
  logic            resp1_valid;
  logic            resp1_ready;

  logic [2*DW-1:0] resp_result;
  logic            busy;
  logic            owner;

  logic            div_rst;
  logic [DW-1:0]   div_a;
  logic [DW-1:0]   div_b;
  logic            div_sign;
  logic            div_opn_valid;
  logic            div_res_valid;
  logic            div_res_ready;
  logic [2*DW-1:0] div_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sign, req0_flush, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_sign, req1_flush, resp1_ready,
    output req0_ready, resp0_valid, req1_ready, resp1_valid,
    output resp_result, busy, owner,
    output div_rst, div_a, div_b, div_sign, div_opn_valid, div_res_ready,
    input  div_res_valid, div_result
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sign, req0_flush, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_sign, req1_flush, resp1_ready,
    input  req0_ready, resp0_valid, req1_ready, resp1_valid,
    input  resp_result, busy, owner,
    input  div_rst, div_a, div_b, div_sign, div_opn_valid, div_res_ready,
    output div_res_valid, div_result
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Shares one radix-2 divider between two requesters: round-robin grant,
// operand latching, result routing and abort of a flushed owner's division.
module div_share_ctrl #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  div_share_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE, S_ABORT} state_t;

  state_t          r_state;
  logic            r_rrPtr;
  logic            r_owner;
  logic            r_sign;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [2*DW-1:0] r_result;
  logic            r_opnValid;
  logic            r_resReady;
  logic            r_resp0Valid;
  logic            r_resp1Valid;
  logic            r_abort;

  logic w_elig0;
  logic w_elig1;
  logic w_grant1;
  logic w_accept;
  logic w_ownerFlush;
  logic w_ownerTake;

  assign w_elig0      = bus.req0_valid & ~bus.req0_flush;
  assign w_elig1      = bus.req1_valid & ~bus.req1_flush;
  assign w_grant1     = w_elig1 & (~w_elig0 | r_rrPtr);
  assign w_accept     = resetn & (r_state == S_IDLE) & (w_elig0 | w_elig1);
  assign w_ownerFlush = r_owner ? bus.req1_flush : bus.req0_flush;
  assign w_ownerTake  = r_owner ? bus.resp1_ready : bus.resp0_ready;

  // Handshake outputs are forced low while reset is held so nothing leaks mid-reset.
  assign bus.req0_ready    = w_accept & ~w_grant1;
  assign bus.req1_ready    = w_accept & w_grant1;
  assign bus.resp0_valid   = resetn & r_resp0Valid;
  assign bus.resp1_valid   = resetn & r_resp1Valid;
  assign bus.resp_result   = r_result;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.owner         = r_owner;
  assign bus.div_rst       = ~resetn | r_abort;
  assign bus.div_a         = r_a;
  assign bus.div_b         = r_b;
  assign bus.div_sign      = r_sign;
  assign bus.div_opn_valid = resetn & r_opnValid;
  assign bus.div_res_ready = resetn & r_resReady;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_rrPtr      <= 1'b0;
      r_owner      <= 1'b0;
      r_sign       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_opnValid   <= 1'b0;
      r_resReady   <= 1'b0;
      r_resp0Valid <= 1'b0;
      r_resp1Valid <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a        <= w_grant1 ? bus.req1_a : bus.req0_a;
            r_b        <= w_grant1 ? bus.req1_b : bus.req0_b;
            r_sign     <= w_grant1 ? bus.req1_sign : bus.req0_sign;
            r_owner    <= w_grant1;
            r_rrPtr    <= ~w_grant1;
            r_opnValid <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_opnValid <= 1'b0;
          if (w_ownerFlush) begin
            r_abort <= 1'b1;
            r_state <= S_ABORT;
          end else begin
            r_resReady <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        // A flush wins over a simultaneous result; the divider is reset instead.
        S_BUSY: begin
          if (w_ownerFlush) begin
            r_resReady <= 1'b0;
            r_abort    <= 1'b1;
            r_state    <= S_ABORT;
          end else if (bus.div_res_valid) begin
            r_resReady   <= 1'b0;
            r_result     <= bus.div_result;
            r_resp0Valid <= ~r_owner;
            r_resp1Valid <= r_owner;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_ownerFlush | w_ownerTake) begin
            r_resp0Valid <= 1'b0;
            r_resp1Valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_ABORT: begin
          r_abort <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_noOpnWhileRes: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.div_opn_valid && bus.div_res_valid));
  a_oneResp: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.resp0_valid && bus.resp1_valid));
  a_readyIdle: assert property (@(posedge clk) disable iff (!resetn)
    (bus.req0_ready || bus.req1_ready) |-> (r_state == S_IDLE));

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: a behavioural 33-cycle divider model plus
// randomized transactions checked against plain-arithmetic expected results.
module tb_div_share_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   nChecks = 0;
  int   nFails = 0;

  div_share_ctrl_if #(.DW(32)) bus ();

  div_share_ctrl #(.DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  // Divider model: result appears 33 cycles after the operand strobe.
  logic        divBusy;
  logic [5:0]  divCnt;
  logic [31:0] mA;
  logic [31:0] mB;
  logic        mSign;

  always @(posedge clk) begin
    if (bus.div_rst) begin
      divBusy           <= 1'b0;
      divCnt            <= 6'd0;
      bus.div_res_valid <= 1'b0;
      bus.div_result    <= 64'd0;
    end else begin
      if (bus.div_res_valid && bus.div_res_ready) bus.div_res_valid <= 1'b0;
      if (bus.div_opn_valid) begin
        divBusy <= 1'b1;
        divCnt  <= 6'd32;
        mA      <= bus.div_a;
        mB      <= bus.div_b;
        mSign   <= bus.div_sign;
      end else if (divBusy) begin
        if (divCnt == 6'd1) begin
          divBusy           <= 1'b0;
          bus.div_res_valid <= 1'b1;
          bus.div_result    <= refDiv(mA, mB, mSign);
        end
        divCnt <= divCnt - 6'd1;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic setReq(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sign = s;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sign = s;
    end
  endtask

  task automatic setFlush(input int p, input logic v);
    if (p == 0) bus.req0_flush = v;
    else        bus.req1_flush = v;
  endtask

  task automatic setRespReady(input int p, input logic v);
    if (p == 0) bus.resp0_ready = v;
    else        bus.resp1_ready = v;
  endtask

  function automatic logic reqReady(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic respValid(input int p);
    return (p == 0) ? bus.resp0_valid : bus.resp1_valid;
  endfunction

  task automatic clearInputs();
    setReq(0, 1'b0, 32'd0, 32'd0, 1'b0);
    setReq(1, 1'b0, 32'd0, 32'd0, 1'b0);
    setFlush(0, 1'b0);
    setFlush(1, 1'b0);
    setRespReady(0, 1'b0);
    setRespReady(1, 1'b0);
  endtask

  task automatic applyReset();
    resetn = 1'b0;
    clearInputs();
    nextCycle();
    nextCycle();
    resetn = 1'b1;
  endtask

  // Drives one request on port p and takes the response immediately; reports what it saw.
  task automatic runTxn(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int acceptWait, output int latency, output logic [63:0] result,
                        output bit otherSeen, output bit opnSeen, output logic ownerAtResp,
                        output bit timedOut);
    timedOut = 0; otherSeen = 0; opnSeen = 0; latency = 0; result = 64'd0;
    ownerAtResp = 1'b0; acceptWait = 0;
    setReq(p, 1'b1, a, b, s);
    sample();
    while (!reqReady(p) && acceptWait < 50) begin
      nextCycle(); sample(); acceptWait++;
    end
    if (!reqReady(p)) begin
      timedOut = 1; setReq(p, 1'b0, 32'd0, 32'd0, 1'b0); nextCycle(); return;
    end
    nextCycle();
    setReq(p, 1'b0, $urandom, $urandom, 1'b0);
    latency = 1;
    sample();
    opnSeen = bus.div_opn_valid;
    while (!respValid(p) && latency < 100) begin
      if (respValid(1 - p)) otherSeen = 1;
      nextCycle(); sample(); latency++;
    end
    if (!respValid(p)) begin
      timedOut = 1; nextCycle(); return;
    end
    if (respValid(1 - p)) otherSeen = 1;
    result = bus.resp_result;
    ownerAtResp = bus.owner;
    setRespReady(p, 1'b1);
    nextCycle();
    setRespReady(p, 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clearInputs();
    setReq(0, 1'b1, 32'd5, 32'd1, 1'b0);
    nextCycle(); nextCycle(); sample();
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    nChecks++; if (bus.owner !== 1'b0) begin nFails++; $display("[TB] FAIL reset_owner: got %b expected 0", bus.owner); end
    nChecks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_req_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
    nChecks++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_resp_valid: got %b expected 00", {bus.resp0_valid, bus.resp1_valid}); end
    nChecks++; if ({bus.div_opn_valid, bus.div_res_ready} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_div_hs: got %b expected 00", {bus.div_opn_valid, bus.div_res_ready}); end
    nChecks++; if (bus.div_rst !== 1'b1) begin nFails++; $display("[TB] FAIL reset_div_rst: got %b expected 1", bus.div_rst); end
    nChecks++; if (bus.resp_result !== 64'd0) begin nFails++; $display("[TB] FAIL reset_result: got %h expected 0", bus.resp_result); end
    nChecks++; if ({bus.div_a, bus.div_b} !== 64'd0) begin nFails++; $display("[TB] FAIL reset_operands: got %h expected 0", {bus.div_a, bus.div_b}); end
    nextCycle();
    resetn = 1'b1;
    setReq(0, 1'b0, 32'd0, 32'd0, 1'b0);
    sample();
    nChecks++; if (bus.div_rst !== 1'b0) begin nFails++; $display("[TB] FAIL reset_release_div_rst: got %b expected 0", bus.div_rst); end
    nextCycle();
  endtask

  task automatic test_unsigned();
    int aw; int lat; logic [63:0] res; bit oth; bit opn; logic own; bit to;
    runTxn(0, 32'd100, 32'd7, 1'b0, aw, lat, res, oth, opn, own, to);
    nChecks++; if (to || aw != 0) begin nFails++; $display("[TB] FAIL unsigned_accept: timeout %0d wait %0d expected 0", to, aw); end
    nChecks++; if (opn !== 1'b1) begin nFails++; $display("[TB] FAIL unsigned_opn_valid: got %b expected 1 at T+1", opn); end
    nChecks++; if (lat != 35) begin nFails++; $display("[TB] FAIL unsigned_latency: got %0d expected 35", lat); end
    nChecks++; if (res !== 64'h00000002_0000000E) begin nFails++; $display("[TB] FAIL unsigned_result: got %h expected 000000020000000e", res); end
    nChecks++; if (oth) begin nFails++; $display("[TB] FAIL unsigned_other_resp: got 1 expected 0"); end
  endtask

  task automatic test_signed();
    int aw; int lat; logic [63:0] res; bit oth; bit opn; logic own; bit to;
    runTxn(1, 32'hFFFF_FFF9, 32'd2, 1'b1, aw, lat, res, oth, opn, own, to);
    nChecks++; if (to || lat != 35) begin nFails++; $display("[TB] FAIL signed_latency: timeout %0d got %0d expected 35", to, lat); end
    nChecks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin nFails++; $display("[TB] FAIL signed_result: got %h expected fffffffffffffffd", res); end
    nChecks++; if (own !== 1'b1) begin nFails++; $display("[TB] FAIL signed_owner: got %b expected 1", own); end
    nChecks++; if (oth) begin nFails++; $display("[TB] FAIL signed_resp0_valid: got 1 expected 0"); end
  endtask

  task automatic test_contention();
    logic [31:0] opA[2];
    logic [31:0] opB[2];
    logic        opS[2];
    int rr; int w; int win; logic [63:0] expRes;
    applyReset();
    rr = 0;
    for (int p = 0; p < 2; p++) begin
      opA[p] = $urandom; opB[p] = $urandom_range(1, 1000); opS[p] = 1'($urandom_range(0, 1));
      setReq(p, 1'b1, opA[p], opB[p], opS[p]);
    end
    for (int n = 0; n < 4; n++) begin
      w = 0;
      sample();
      while (!(bus.req0_ready | bus.req1_ready) && w < 60) begin nextCycle(); sample(); w++; end
      win = bus.req1_ready ? 1 : 0;
      nChecks++; if (!(bus.req0_ready | bus.req1_ready) || win != rr) begin nFails++; $display("[TB] FAIL contention_grant%0d: got port %0d expected port %0d", n, win, rr); end
      nChecks++; if (bus.req0_ready & bus.req1_ready) begin nFails++; $display("[TB] FAIL contention_double_grant%0d: got 11 expected one-hot", n); end
      if (n > 0) begin
        nChecks++; if (w != 0) begin nFails++; $display("[TB] FAIL contention_gap%0d: got %0d idle cycles expected 0", n, w); end
      end
      expRes = refDiv(opA[win], opB[win], opS[win]);
      rr = 1 - win;
      nextCycle();
      opA[win] = $urandom; opB[win] = $urandom_range(1, 1000); opS[win] = 1'($urandom_range(0, 1));
      setReq(win, 1'b1, opA[win], opB[win], opS[win]);
      w = 0;
      sample();
      while (!respValid(win) && w < 100) begin nextCycle(); sample(); w++; end
      nChecks++; if (!respValid(win) || bus.resp_result !== expRes) begin nFails++; $display("[TB] FAIL contention_result%0d: got %h expected %h", n, bus.resp_result, expRes); end
      nChecks++; if (respValid(1 - win)) begin nFails++; $display("[TB] FAIL contention_nonowner_valid%0d: got 1 expected 0", n); end
      setRespReady(win, 1'b1);
      nextCycle();
      setRespReady(win, 1'b0);
    end
    setReq(0, 1'b0, 32'd0, 32'd0, 1'b0);
    setReq(1, 1'b0, 32'd0, 32'd0, 1'b0);
    nextCycle();
  endtask

  task automatic test_flush_busy();
    logic [31:0] a; logic [31:0] b; bit seenResp; int w;
    int aw; int lat; logic [63:0] res; bit oth; bit opn; logic own; bit to;
    a = $urandom; b = $urandom | 32'd1; seenResp = 0; w = 0;
    setReq(0, 1'b1, a, b, 1'b0);
    sample();
    while (!bus.req0_ready && w < 50) begin nextCycle(); sample(); w++; end
    nChecks++; if (!bus.req0_ready) begin nFails++; $display("[TB] FAIL flush_accept: got 0 expected 1"); end
    for (int k = 1; k <= 40; k++) begin
      nextCycle();
      if (k == 1) setReq(0, 1'b0, 32'd0, 32'd0, 1'b0);
      setFlush(0, k == 10);
      sample();
      if (bus.resp0_valid | bus.resp1_valid) seenResp = 1;
      if (k == 11) begin
        nChecks++; if (bus.div_rst !== 1'b1) begin nFails++; $display("[TB] FAIL flush_abort_div_rst: got %b expected 1", bus.div_rst); end
        nChecks++; if (bus.busy !== 1'b1) begin nFails++; $display("[TB] FAIL flush_abort_busy: got %b expected 1", bus.busy); end
      end
      if (k == 12) begin
        nChecks++; if ({bus.busy, bus.div_rst} !== 2'b00) begin nFails++; $display("[TB] FAIL flush_idle: got busy,div_rst=%b expected 00", {bus.busy, bus.div_rst}); end
      end
    end
    nChecks++; if (seenResp) begin nFails++; $display("[TB] FAIL flush_no_resp: got resp_valid expected none"); end
    nextCycle();
    runTxn(0, 32'd100, 32'd7, 1'b0, aw, lat, res, oth, opn, own, to);
    nChecks++; if (to || lat != 35 || res !== 64'h00000002_0000000E) begin nFails++; $display("[TB] FAIL flush_recover: got %h latency %0d expected 000000020000000e latency 35", res, lat); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a; logic [31:0] b; logic s; logic [63:0] expRes; int w;
    for (int v = 0; v < 2; v++) begin
      a = $urandom; b = $urandom_range(1, 65535); s = 1'($urandom_range(0, 1));
      expRes = refDiv(a, b, s);
      w = 0;
      setReq(0, 1'b1, a, b, s);
      sample();
      while (!bus.req0_ready && w < 50) begin nextCycle(); sample(); w++; end
      nextCycle();
      setReq(0, 1'b0, $urandom, $urandom, 1'b1);
      w = 0;
      sample();
      while (!bus.resp0_valid && w < 100) begin nextCycle(); sample(); w++; end
      nChecks++; if (!bus.resp0_valid) begin nFails++; $display("[TB] FAIL bp_resp_timeout%0d: got 0 expected resp0_valid", v); end
      if (v == 0) begin
        for (int k = 0; k < 20; k++) begin
          nChecks++; if (!bus.resp0_valid || bus.resp_result !== expRes) begin nFails++; $display("[TB] FAIL bp_hold%0d: got valid %b result %h expected 1 %h", k, bus.resp0_valid, bus.resp_result, expRes); end
          nextCycle(); sample();
        end
        setRespReady(0, 1'b1);
      end else begin
        setFlush(0, 1'b1);
      end
      nextCycle();
      setRespReady(0, 1'b0);
      setFlush(0, 1'b0);
      sample();
      nChecks++; if ({bus.resp0_valid, bus.busy} !== 2'b00) begin nFails++; $display("[TB] FAIL bp_release%0d: got valid,busy=%b expected 00", v, {bus.resp0_valid, bus.busy}); end
      nextCycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; logic [31:0] b; bit seenResp; int w;
    int aw; int lat; logic [63:0] res; bit oth; bit opn; logic own; bit to;
    a = $urandom; b = $urandom_range(1, 255); seenResp = 0; w = 0;
    setReq(1, 1'b1, a, b, 1'b1);
    sample();
    while (!bus.req1_ready && w < 50) begin nextCycle(); sample(); w++; end
    for (int k = 1; k <= 15; k++) begin
      nextCycle();
      if (k == 1) setReq(1, 1'b0, 32'd0, 32'd0, 1'b0);
      if (k == 15) resetn = 1'b0;
      sample();
    end
    nChecks++; if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.div_opn_valid, bus.div_res_ready} !== 6'd0) begin nFails++; $display("[TB] FAIL midreset_outputs: got %b expected 000000", {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.div_opn_valid, bus.div_res_ready}); end
    nChecks++; if (bus.div_rst !== 1'b1) begin nFails++; $display("[TB] FAIL midreset_div_rst: got %b expected 1", bus.div_rst); end
    nextCycle();
    resetn = 1'b1;
    sample();
    nChecks++; if ({bus.busy, bus.owner, bus.div_rst} !== 3'b000 || bus.resp_result !== 64'd0) begin nFails++; $display("[TB] FAIL midreset_after: got busy,owner,div_rst=%b result %h expected 000 0", {bus.busy, bus.owner, bus.div_rst}, bus.resp_result); end
    for (int k = 0; k < 40; k++) begin
      nextCycle(); sample();
      if (bus.resp0_valid | bus.resp1_valid) seenResp = 1;
    end
    nChecks++; if (seenResp) begin nFails++; $display("[TB] FAIL midreset_stale_resp: got resp_valid expected none"); end
    nextCycle();
    a = $urandom; b = $urandom_range(1, 4095);
    runTxn(1, a, b, 1'b0, aw, lat, res, oth, opn, own, to);
    nChecks++; if (to || lat != 35 || res !== refDiv(a, b, 1'b0)) begin nFails++; $display("[TB] FAIL midreset_recover: got %h latency %0d expected %h latency 35", res, lat, refDiv(a, b, 1'b0)); end
  endtask

  task automatic test_random();
    logic [31:0] a; logic [31:0] b; logic s; int p;
    int aw; int lat; logic [63:0] res; bit oth; bit opn; logic own; bit to;
    for (int n = 0; n < 10; n++) begin
      p = $urandom_range(0, 1);
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom_range(1, 1000);
      endcase
      if (n == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
      runTxn(p, a, b, s, aw, lat, res, oth, opn, own, to);
      nChecks++; if (to || res !== refDiv(a, b, s)) begin nFails++; $display("[TB] FAIL random_result%0d: port %0d got %h expected %h", n, p, res, refDiv(a, b, s)); end
      nChecks++; if (lat != 35 || aw != 0 || oth || own !== 1'(p)) begin nFails++; $display("[TB] FAIL random_protocol%0d: latency %0d wait %0d other %0d owner %b expected 35 0 0 %0d", n, lat, aw, oth, own, p); end
    end
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_unsigned();
    test_signed();
    test_contention();
    test_flush_busy();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
